// File: rtl/mips_pkg.sv
// MD op encodings, default MDU latencies and op-class helpers shared by the MDU and the controller.
// Pure declarations; no latency, no backpressure.
package mips_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic md_is_arith(input logic [2:0] op);
    return op <= MD_DIVU;
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// ID/EX-to-MDU bundle: op request and operands in, busy/stall and HI/LO out.
// Single-cycle start pulse; the hazard unit uses stall_req to keep start away while busy.
interface mdu_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, a, b,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, md_op, a, b,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/mdu_unit.sv
// MIPS multiply/divide unit holding HI/LO; mult takes MULT_CYCLES, div DIV_CYCLES, mthi/mtlo one edge.
// Starts arriving while busy are dropped. MDU_DIV0_GUARD_EN: divide by zero finishes in 1 cycle, HI/LO kept.
module mdu_unit
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, den, q_mag, r_mag, quot, rem;
  logic [63:0] result;
  logic        commit_en;

  // Signed division runs on magnitudes so that 0x80000000 / -1 wraps back to 0x80000000 naturally.
  always_comb begin
    div_signed = (op_q == MD_DIV);
    a_neg      = div_signed & a_q[31];
    b_neg      = div_signed & b_q[31];
    a_mag      = a_neg ? -a_q : a_q;
    b_mag      = b_neg ? -b_q : b_q;
    den        = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / den;
    r_mag      = a_mag % den;
    quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem        = a_neg ? -r_mag : r_mag;
    result     = 64'd0;
    case (op_q)
      MD_MULT:  result = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      MD_MULTU: result = {32'd0, a_q} * {32'd0, b_q};
      default: begin
        if (b_q == 32'd0) result = {a_q, 32'hFFFF_FFFF};
        else              result = {rem, quot};
      end
    endcase
`ifdef MDU_DIV0_GUARD_EN
    commit_en = !(md_is_div(op_q) && (b_q == 32'd0));
`else
    commit_en = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (md.start) begin
          if (md_is_arith(md.md_op)) begin
            state_d = MD_BUSY;
            op_d    = md.md_op;
            a_d     = md.a;
            b_d     = md.b;
            cnt_d   = md_is_div(md.md_op) ? DIV_LOAD : MULT_LOAD;
`ifdef MDU_DIV0_GUARD_EN
            if (md_is_div(md.md_op) && (md.b == 32'd0)) cnt_d = '0;
`endif
          end else if (md.md_op == MD_MTHI) begin
            hi_d = md.a;
          end else if (md.md_op == MD_MTLO) begin
            lo_d = md.a;
          end
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
          if (commit_en) begin
            hi_d = result[63:32];
            lo_d = result[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    md.busy      = (state_q == MD_BUSY);
    md.stall_req = md.start | (state_q == MD_BUSY);
    md.hi        = hi_q;
    md.lo        = lo_q;
  end

endmodule
